aes_key_expand_multi: RTL and testbench
=======================================

// Module: aes_key_expand_multi
// PURPOSE
//  Iterative AES key-schedule engine for AES-128/192/256, selected per job by a mode input.
//  - Generates one 32-bit schedule word per cycle.
//  - Streams round keys 0..Nr to the cipher datapath over a valid/ready handshake.
//  - Shares an external combinational S-box through sub_o/sub_i.
//  - Successor to the fixed 128-bit single-round key generator; it owns round sequencing,
//    Rcon generation and backpressure itself.
// PARAMETERS
//  MAX_KEY_BITS  256  largest supported key: 128, 192 or 256. Modes above this are rejected.
//  RK_W          128  round-key width; fixed at 4 words, must remain 128.
// PORTS
//  clk        in   1    clock, rising edge
//  nrst       in   1    reset nrst, synchronous, active-low
//  start      in   1    job request; accepted only when busy=0
//  mode       in   2    0=AES-128 (Nk4,Nr10), 1=AES-192 (Nk6,Nr12), 2=AES-256 (Nk8,Nr14), 3=illegal
//  key_i      in   256  cipher key; word0 = key_i[255:224]. AES-128/192 use the upper 128/192 bits.
//  busy       out  1    job in progress
//  err        out  1    one-cycle pulse: start with illegal or unsupported mode
//  sub_o      out  32   word sent to the S-box (RotWord applied when required)
//  sub_i      in   32   SubWord(sub_o), combinational, same cycle
//  rk_valid   out  1    round key present on rk_o
//  rk_ready   in   1    consumer accepts rk_o
//  rk_o       out  128  round key; word0 in [127:96]
//  rk_idx     out  4    round index of rk_o, 0..Nr
//  rk_last    out  1    rk_o is round Nr
// BEHAVIOUR
//  Reset (nrst=0 at a clock edge) clears all outputs, all registers and the 8-word window.
//  - State returns to IDLE, rcon resets to 8'h01.
//  - Reset mid-job aborts it; no further rk_valid.
//  FSM states: IDLE, RUN, DRAIN.
//  IDLE:
//  - start=1 with legal mode: latch key_i and mode, set word counter i=0, rcon=01, go RUN.
//    busy=1 from the next cycle.
//  - start=1 with illegal mode: err pulses for 1 cycle, stay IDLE.
//  - While busy=1, start is ignored.
//  RUN: each cycle that is not stalled produces word w[i] and increments i.
//  - For i<Nk: w[i] = key word i.
//  - For i>=Nk: w[i] = w[i-Nk] ^ t, where:
//    - i%Nk==0: t = sub_i ^ {rcon,24'h0}, with sub_o = RotWord(w[i-1]); rcon then advances
//      by xtime (80 -> 1B).
//    - Nk==8 and i%Nk==4: t = sub_i, with sub_o = w[i-1].
//    - Otherwise: t = w[i-1], and sub_o = 0.
//  - The window holds the last 8 words; w[i-Nk] is selected by Nk.
//  Collector:
//  - Words fill a 4-word collector.
//  - On the 4th word, the collector transfers to rk_o. At the same edge, rk_valid=1 and
//    rk_idx = i/4.
//  Handshake:
//  - A transfer completes on rk_valid & rk_ready.
//  - rk_o, rk_idx and rk_last stay stable while rk_valid & !rk_ready.
//  - Stall rule: the collector holds 3 words and rk_valid & !rk_ready. Generation freezes:
//    i, rcon and the window hold, and sub_o holds.
//  - Same-cycle accept plus transfer of a new key is allowed: no bubble.
//  Timing:
//  - Start accepted at edge E0: rk0 is valid after E4. With rk_ready=1, a new round key
//    arrives every 4 cycles.
//  - Total words: 4*(Nr+1) = 44, 52 or 60.
//  - For i = total-1, the RUN state transfers with rk_last=1 and goes to DRAIN.
//  DRAIN: on accept of rk_last, rk_valid=0, busy=0, go IDLE. The next start may be accepted
//  in the following cycle.
//  Widths: all word arithmetic is 32-bit XOR; rcon is 8-bit; i is 6-bit and does not wrap
//  (maximum 59).
// TESTING
//  T1 AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
//     - rk0 equals the key.
//     - rk1 = a0fafe1788542cb123a339392a6c7605.
//     - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last=1 and rk_idx=10.
//  T2 AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
//     - 13 round keys.
//     - rk12 = e98ba06f448c773c8ecc720401002202.
//  T3 AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
//     - 15 round keys.
//     - rk14 = fe4890d1e6188d0b046df344706c631e.
//  T4 T1 with random rk_ready backpressure (about 50% duty):
//     - Identical key sequence.
//     - rk_o stable while stalled.
//     - No lost or duplicated rk_idx.
//  T5 Reset and mode errors:
//     - nrst=0 at rk_idx=5 of T1: busy, rk_valid and all outputs are 0 on the next cycle.
//     - Restarting T1 reproduces rk1 exactly, which proves rcon restarts at 01.
//     - mode=3 produces an err pulse and busy stays 0.
//  T6 Start handling:
//     - start held high across a whole job is ignored while busy.
//     - A back-to-back start in the cycle after DRAIN begins a new job with a correct rk0.

Source files
------------

// File: rtl/aes_key_expand_multi.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per cycle, round keys streamed
// over valid/ready. SubWord is performed by an external combinational S-box via sub_o/sub_i.
module aes_key_expand_multi #(
   parameter int unsigned MAX_KEY_BITS = 256,
   parameter int unsigned RK_W         = 128
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            start,
   input  logic [1:0]      mode,
   input  logic [255:0]    key_i,
   output logic            busy,
   output logic            err,
   output logic [31:0]     sub_o,
   input  logic [31:0]     sub_i,
   output logic            rk_valid,
   input  logic            rk_ready,
   output logic [RK_W-1:0] rk_o,
   output logic [3:0]      rk_idx,
   output logic            rk_last
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [7:0][31:0]  key_q, key_d;
   logic [5:0]        i_q, i_d;
   logic [2:0]        ph_q, ph_d;
   logic [7:0]        rcon_q, rcon_d;
   logic [7:0][31:0]  win_q, win_d;
   logic [2:0][31:0]  col_q, col_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [RK_W-1:0]   rk_q, rk_d;
   logic              rk_valid_q, rk_valid_d;
   logic [3:0]        rk_idx_q, rk_idx_d;
   logic              rk_last_q, rk_last_d;
   logic              err_q, err_d;

   logic [3:0]  nk;
   logic [5:0]  last_i;
   logic [31:0] w_nk;
   logic [31:0] w_prev;
   logic [31:0] word;
   logic        from_key;
   logic        rot_sel;
   logic        pass_sel;
   logic        mode_ok;
   logic        accept;
   logic        stall;

   always_comb begin
      mode_ok = 1'b0;
      unique case (mode)
         2'd0:    mode_ok = (MAX_KEY_BITS >= 32'd128);
         2'd1:    mode_ok = (MAX_KEY_BITS >= 32'd192);
         2'd2:    mode_ok = (MAX_KEY_BITS >= 32'd256);
         default: mode_ok = 1'b0;
      endcase
   end

   // w[i-Nk] sits at window slot Nk-1 because slot 0 always holds w[i-1].
   always_comb begin
      nk     = 4'd8;
      last_i = 6'd59;
      w_nk   = win_q[7];
      unique case (mode_q)
         2'd0: begin
            nk     = 4'd4;
            last_i = 6'd43;
            w_nk   = win_q[3];
         end
         2'd1: begin
            nk     = 4'd6;
            last_i = 6'd51;
            w_nk   = win_q[5];
         end
         default: begin
            nk     = 4'd8;
            last_i = 6'd59;
            w_nk   = win_q[7];
         end
      endcase
   end

   always_comb begin
      w_prev   = win_q[0];
      from_key = (i_q < 6'(nk));
      rot_sel  = (state_q == StRun) && !from_key && (ph_q == 3'd0);
      pass_sel = (state_q == StRun) && !from_key && (mode_q == 2'd2) && (ph_q == 3'd4);
      sub_o    = 32'h0;
      if (rot_sel) begin
         sub_o = {w_prev[23:0], w_prev[31:24]};
      end else if (pass_sel) begin
         sub_o = w_prev;
      end
      word = w_nk ^ w_prev;
      if (from_key) begin
         word = key_q[3'd7 - i_q[2:0]];
      end else if (rot_sel) begin
         word = w_nk ^ sub_i ^ {rcon_q, 24'h0};
      end else if (pass_sel) begin
         word = w_nk ^ sub_i;
      end
   end

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      key_d      = key_q;
      i_d        = i_q;
      ph_d       = ph_q;
      rcon_d     = rcon_q;
      win_d      = win_q;
      col_d      = col_q;
      cnt_d      = cnt_q;
      rk_d       = rk_q;
      rk_valid_d = rk_valid_q;
      rk_idx_d   = rk_idx_q;
      rk_last_d  = rk_last_q;
      err_d      = 1'b0;

      accept = rk_valid_q && rk_ready;
      // Only the 4th word needs the output register; words 1-3 can always land in the collector.
      stall  = (cnt_q == 2'd3) && rk_valid_q && !rk_ready;

      if (accept) begin
         rk_valid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (mode_ok) begin
                  key_d   = key_i;
                  mode_d  = mode;
                  i_d     = 6'd0;
                  ph_d    = 3'd0;
                  rcon_d  = 8'h01;
                  cnt_d   = 2'd0;
                  state_d = StRun;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (!stall) begin
               win_d = {win_q[6:0], word};
               i_d   = i_q + 6'd1;
               ph_d  = ({1'b0, ph_q} == nk - 4'd1) ? 3'd0 : ph_q + 3'd1;
               if (rot_sel) begin
                  rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
               end
               if (cnt_q == 2'd3) begin
                  rk_d       = {col_q[0], col_q[1], col_q[2], word};
                  rk_valid_d = 1'b1;
                  rk_idx_d   = i_q[5:2];
                  rk_last_d  = (i_q == last_i);
                  cnt_d      = 2'd0;
                  if (i_q == last_i) begin
                     state_d = StDrain;
                  end
               end else begin
                  col_d[cnt_q] = word;
                  cnt_d        = cnt_q + 2'd1;
               end
            end
         end
         StDrain: begin
            if (accept) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q    <= StIdle;
         mode_q     <= 2'd0;
         key_q      <= '0;
         i_q        <= 6'd0;
         ph_q       <= 3'd0;
         rcon_q     <= 8'h01;
         win_q      <= '0;
         col_q      <= '0;
         cnt_q      <= 2'd0;
         rk_q       <= '0;
         rk_valid_q <= 1'b0;
         rk_idx_q   <= 4'd0;
         rk_last_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         key_q      <= key_d;
         i_q        <= i_d;
         ph_q       <= ph_d;
         rcon_q     <= rcon_d;
         win_q      <= win_d;
         col_q      <= col_d;
         cnt_q      <= cnt_d;
         rk_q       <= rk_d;
         rk_valid_q <= rk_valid_d;
         rk_idx_q   <= rk_idx_d;
         rk_last_q  <= rk_last_d;
         err_q      <= err_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign err      = err_q;
   assign rk_valid = rk_valid_q;
   assign rk_o     = rk_q;
   assign rk_idx   = rk_idx_q;
   assign rk_last  = rk_last_q;

endmodule

// File: tb/tb_aes_key_expand_multi.sv
// Bench for aes_key_expand_multi: FIPS-197 style key expansion model with a computed S-box,
// a per-cycle round-key monitor, and directed plus random jobs.
module tb_aes_key_expand_multi;

   logic         clk = 1'b0;
   logic         nrst;
   logic         start;
   logic [1:0]   mode;
   logic [255:0] key_i;
   logic         busy;
   logic         err;
   logic [31:0]  sub_o;
   logic [31:0]  sub_i;
   logic         rk_valid;
   logic         rk_ready = 1'b1;
   logic [127:0] rk_o;
   logic [3:0]   rk_idx;
   logic         rk_last;

   aes_key_expand_multi dut (
      .clk      (clk),
      .nrst     (nrst),
      .start    (start),
      .mode     (mode),
      .key_i    (key_i),
      .busy     (busy),
      .err      (err),
      .sub_o    (sub_o),
      .sub_i    (sub_i),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_o     (rk_o),
      .rk_idx   (rk_idx),
      .rk_last  (rk_last)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]   sbox_t [0:255];
   logic [127:0] exp_rk [0:14];
   logic [127:0] got_rk [0:15];
   int           exp_nr = 10;
   int           mon_idx = 0;
   bit           mon_active = 1'b0;
   bit           mon_done = 1'b0;
   bit           bp_en = 1'b0;

   localparam logic [255:0] KeyT1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KeyT2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] KeyT3 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   assign sub_i = {sbox_t[sub_o[31:24]], sbox_t[sub_o[23:16]],
                   sbox_t[sub_o[15:8]], sbox_t[sub_o[7:0]]};

   task automatic check(input string nm, input logic [255:0] got, input logic [255:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
   endfunction

   // Straightforward expansion: Rcon[j] = 2^(j-1) in GF(2^8).
   task automatic expand(input logic [255:0] key, input int md);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      int nk, tot;
      nk     = 4 + 2 * md;
      exp_nr = nk + 6;
      tot    = 4 * (exp_nr + 1);
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
      for (int i = nk; i < tot; i++) begin
         t = w[i - 1];
         if (i % nk == 0) begin
            rc = 8'h01;
            for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
         end else if (nk == 8 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i - nk] ^ t;
      end
      for (int r = 0; r <= exp_nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rk_ready = bp_en ? ($urandom_range(0, 1) != 0) : 1'b1;
      end
   end

   // Monitor: every visible round key must be the next expected one, and must hold while stalled.
   initial begin
      logic [127:0] prev_rk;
      logic [3:0]   prev_idx;
      logic         prev_last;
      bit           stall_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!nrst) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check("hold_valid", rk_valid, 1'b1);
               check("hold_rk", {rk_o, rk_idx, rk_last}, {prev_rk, prev_idx, prev_last});
            end
            if (rk_valid) begin
               if (!mon_active || mon_idx > 14) begin
                  check("unexpected_valid", rk_valid, 1'b0);
               end else begin
                  check("rk_idx", rk_idx, mon_idx[3:0]);
                  check("rk_o", rk_o, exp_rk[mon_idx]);
                  check("rk_last", rk_last, mon_idx == exp_nr);
                  if (rk_ready) begin
                     got_rk[rk_idx] = rk_o;
                     if (mon_idx == exp_nr) begin
                        mon_active = 1'b0;
                        mon_done   = 1'b1;
                     end
                     mon_idx++;
                  end
               end
            end
            stall_prev = rk_valid && !rk_ready;
            prev_rk    = rk_o;
            prev_idx   = rk_idx;
            prev_last  = rk_last;
         end
      end
   end

   task automatic arm_monitor();
      for (int r = 0; r < 16; r++) got_rk[r] = '0;
      mon_idx    = 0;
      mon_done   = 1'b0;
      mon_active = 1'b1;
   endtask

   task automatic wait_done();
      for (int n = 0; n < 2000 && !mon_done; n++) @(negedge clk);
      check("job_done", mon_done, 1'b1);
      @(negedge clk);
      check("busy_after_job", busy, 1'b0);
   endtask

   task automatic run_job(input logic [255:0] k, input logic [1:0] md, input bit bp);
      expand(k, int'(md));
      bp_en = bp;
      @(posedge clk);
      #1;
      arm_monitor();
      start = 1'b1;
      mode  = md;
      key_i = k;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done();
   endtask

   initial begin
      nrst  = 1'b0;
      start = 1'b0;
      mode  = 2'd0;
      key_i = '0;
      for (int b = 0; b < 256; b++) begin
         logic [7:0] x;
         logic [7:0] inv;
         x   = 8'(b);
         inv = 8'h00;
         if (x != 8'h00) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, x);
         end
         sbox_t[b] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                     {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {busy, err, rk_valid, rk_last, rk_idx, rk_o, sub_o}, '0);

      // Pin the model against known-answer vectors.
      expand(KeyT2, 1);
      check("model_t2_rk12", exp_rk[12], 128'he98ba06f448c773c8ecc720401002202);
      expand(KeyT3, 2);
      check("model_t3_rk14", exp_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
      expand(KeyT1, 0);
      check("model_t1_rk1", exp_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);

      @(posedge clk);
      #1;
      nrst = 1'b1;

      // T1 with exact latency: rk0 after E4, rk10 after E44.
      bp_en = 1'b0;
      @(posedge clk);
      #1;
      arm_monitor();
      start = 1'b1;
      mode  = 2'd0;
      key_i = KeyT1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("busy_after_start", busy, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("no_valid_before_e4", rk_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("rk0_at_e4", {rk_valid, rk_idx}, {1'b1, 4'd0});
      repeat (40) @(posedge clk);
      @(negedge clk);
      check("rk10_at_e44", {rk_valid, rk_last, rk_idx}, {1'b1, 1'b1, 4'd10});
      wait_done();
      check("t1_rk0", got_rk[0], KeyT1[255:128]);
      check("t1_rk1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
      check("t1_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      run_job(KeyT2, 2'd1, 1'b0);
      check("t2_rk12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);
      run_job(KeyT3, 2'd2, 1'b0);
      check("t3_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

      // T4: backpressure.
      run_job(KeyT1, 2'd0, 1'b1);
      check("t4_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // T5: reset mid-job, restart, illegal mode.
      expand(KeyT1, 0);
      bp_en = 1'b0;
      @(posedge clk);
      #1;
      arm_monitor();
      start = 1'b1;
      mode  = 2'd0;
      key_i = KeyT1;
      @(posedge clk);
      #1;
      start = 1'b0;
      begin
         bit seen = 1'b0;
         for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            seen = rk_valid && (rk_idx == 4'd5);
         end
         check("reached_idx5", seen, 1'b1);
      end
      nrst = 1'b0;
      @(posedge clk);
      #1;
      mon_active = 1'b0;
      @(negedge clk);
      check("mid_reset_outputs", {busy, err, rk_valid, rk_last, rk_idx, rk_o, sub_o}, '0);
      @(posedge clk);
      #1;
      nrst = 1'b1;
      repeat (10) @(posedge clk);
      run_job(KeyT1, 2'd0, 1'b0);
      check("restart_rk1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);

      @(posedge clk);
      #1;
      start = 1'b1;
      mode  = 2'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("err_pulse", {err, busy}, {1'b1, 1'b0});
      @(negedge clk);
      check("err_clear", {err, busy}, {1'b0, 1'b0});

      // T6: start held through job A, then back-to-back job B right after DRAIN.
      expand(KeyT1, 0);
      bp_en = 1'b0;
      @(posedge clk);
      #1;
      arm_monitor();
      start = 1'b1;
      mode  = 2'd0;
      key_i = KeyT1;
      begin
         bit seen = 1'b0;
         for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            seen = rk_valid && rk_ready && rk_last;
         end
         check("held_start_last", seen, 1'b1);
      end
      @(posedge clk);
      #1;
      expand(KeyT2, 1);
      arm_monitor();
      mode  = 2'd1;
      key_i = KeyT2;
      @(negedge clk);
      check("idle_after_drain", busy, 1'b0);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("back_to_back_busy", busy, 1'b1);
      wait_done();
      check("b2b_rk0", got_rk[0], KeyT2[255:128]);
      check("b2b_rk12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);

      // Random keys, modes and backpressure.
      for (int j = 0; j < 8; j++) begin
         logic [255:0] rk;
         for (int b = 0; b < 8; b++) rk[32*b +: 32] = $urandom();
         run_job(rk, 2'($urandom_range(0, 2)), ($urandom_range(0, 1) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
